led_panel_cmd_parser: RTL and testbench
=======================================

// Module: led_panel_cmd_parser
// PURPOSE
//  Byte-level command decoder between uart_rx and the LED panel frame buffer.
//  Consumes received UART bytes (dv + data) and emits single-cycle write strobes:
//  pixel set/clear, whole-column write, clear-screen and colour select.
//  Panel refresh logic owns the 16-column x 8-row frame buffer and applies the strobes.
// PARAMETERS
//  TIMEOUT_CLKS  1024  idle clocks allowed between opcode and argument byte before abort
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high reset
//  rx_dv        in   1  one-cycle strobe: rx_data valid
//  rx_data      in   8  received byte
//  fb_pix_we    out  1  one-cycle strobe: write fb_bit to frame_buffer[fb_col][fb_row]
//  fb_col_we    out  1  one-cycle strobe: write fb_col_data to frame_buffer[fb_col]
//  fb_col       out  4  target column 0..15
//  fb_row       out  3  target row 0..7 (pixel writes only)
//  fb_bit       out  1  pixel value: 1 = set, 0 = clear
//  fb_col_data  out  8  column word for fb_col_we
//  fb_clr       out  1  one-cycle strobe: clear all 16 columns
//  rgb_we       out  1  one-cycle strobe: load rgb_val as the drawing colour
//  rgb_val      out  3  {r,g,b}
//  err          out  1  one-cycle strobe: bad opcode, bad argument or timeout
//  busy         out  1  high while waiting for an argument byte
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0.
//  - All outputs registered; a strobe asserts exactly 1 clk after the rx_dv that completes
//    the command. At most one strobe is high per cycle. Data outputs hold between strobes.
//  - Opcodes (rx_data[7:4] in IDLE):
//    0x0: rgb_val <= rx_data[2:0], rgb_we pulse; rx_data[3] ignored.
//    0x1: set pixel -> ARG_PIX, fb_bit <= 1.   0x2: clear pixel -> ARG_PIX, fb_bit <= 0.
//    0x3: fb_clr pulse.   0x4: fb_col <= rx_data[3:0] -> ARG_COL.
//    0xF: no-op (includes 0xF5).   0x5..0xE: err pulse, stay IDLE.
//  - ARG_PIX: next byte = {col[3:0], 0, row[2:0]}; bit3 = 1 -> err, no write.
//    Else fb_col/fb_row loaded, fb_pix_we pulse. Back to IDLE either way.
//  - ARG_COL: next byte loaded into fb_col_data, fb_col_we pulse, back to IDLE.
//  - Byte 0xF5 in any ARG state: abort to IDLE, no strobe, no err (resync byte).
//    In ARG_COL, 0xF5 is therefore not writable as column data (documented limitation).
//  - Timeout: counter clears on entry to an ARG state and on every rx_dv; increments each
//    idle clk in ARG. At count == TIMEOUT_CLKS-1: err pulse, return to IDLE.
//    rx_dv on the expiry cycle wins: byte processed as argument, no err.
//  - busy = (state != IDLE). Counter width $clog2(TIMEOUT_CLKS); saturates, never wraps.
//  - Reset asserted mid-command: pending command discarded, no strobe on release.
// STRUCTURE
//  - Shared package led_panel_pkg: opcode nibble constants (OP_RGB, OP_SET, OP_CLR_PIX,
//    OP_CLS, OP_COL, OP_CTRL), RESYNC_BYTE = 8'hF5, parser state encoding
//    (IDLE, ARG_PIX, ARG_COL), panel geometry constants (16 cols, 8 rows).
//  - Single module; the timeout counter stays inline, no sub-module.
// TESTING
//  - Bytes 0x05 -> rgb_we, rgb_val = 3'b101, 1 clk after dv; no other strobe.
//  - 0x10, 0x72 -> fb_pix_we, fb_col = 7, fb_row = 2, fb_bit = 1.
//    Then 0x20, 0x72 -> same address, fb_bit = 0.
//  - 0x4A, 0x3C -> fb_col_we, fb_col = 10, fb_col_data = 8'h3C.
//    0x4A, 0xF5 -> no strobe, no err, busy = 0.
//  - Bad input: 0x18 argument (bit3 set) -> err, no fb_pix_we; opcode 0x77 -> err.
//    0x30 -> fb_clr only.
//  - 0x10 then silence TIMEOUT_CLKS clks -> err once, busy falls.
//    Byte on the expiry cycle -> write, no err. Reset between 0x10 and its argument ->
//    no strobe after release.

Source files
------------

// File: rtl/led_panel_pkg.sv
// rtl/led_panel_pkg.sv - opcodes, resync byte, parser states and panel geometry
package led_panel_pkg;

  localparam logic [3:0] OP_RGB     = 4'h0;
  localparam logic [3:0] OP_SET     = 4'h1;
  localparam logic [3:0] OP_CLR_PIX = 4'h2;
  localparam logic [3:0] OP_CLS     = 4'h3;
  localparam logic [3:0] OP_COL     = 4'h4;
  localparam logic [3:0] OP_CTRL    = 4'hF;

  localparam logic [7:0] RESYNC_BYTE = 8'hF5;

  localparam int NUM_COLS = 16;
  localparam int NUM_ROWS = 8;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARG_PIX = 2'd1,
    ARG_COL = 2'd2
  } parser_state_e;

endpackage

// File: rtl/led_panel_cmd_parser.sv
// rtl/led_panel_cmd_parser.sv - UART byte stream to LED frame-buffer write strobes
module led_panel_cmd_parser
  import led_panel_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  output logic             fb_pix_we,
  output logic             fb_col_we,
  output logic [COL_W-1:0] fb_col,
  output logic [ROW_W-1:0] fb_row,
  output logic             fb_bit,
  output logic [7:0]       fb_col_data,
  output logic             fb_clr,
  output logic             rgb_we,
  output logic [2:0]       rgb_val,
  output logic             err,
  output logic             busy
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

  parser_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pix_we_q, pix_we_d, col_we_q, col_we_d;
  logic             clr_q, clr_d, rgb_we_q, rgb_we_d, err_q, err_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             bit_q, bit_d;
  logic [7:0]       col_data_q, col_data_d;
  logic [2:0]       rgb_q, rgb_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pix_we_q   <= 1'b0;
      col_we_q   <= 1'b0;
      clr_q      <= 1'b0;
      rgb_we_q   <= 1'b0;
      err_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      bit_q      <= 1'b0;
      col_data_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_we_q   <= pix_we_d;
      col_we_q   <= col_we_d;
      clr_q      <= clr_d;
      rgb_we_q   <= rgb_we_d;
      err_q      <= err_d;
      col_q      <= col_d;
      row_q      <= row_d;
      bit_q      <= bit_d;
      col_data_q <= col_data_d;
      rgb_q      <= rgb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pix_we_d   = 1'b0;
    col_we_d   = 1'b0;
    clr_d      = 1'b0;
    rgb_we_d   = 1'b0;
    err_d      = 1'b0;
    col_d      = col_q;
    row_d      = row_q;
    bit_d      = bit_q;
    col_data_d = col_data_q;
    rgb_d      = rgb_q;

    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          case (rx_data[7:4])
            OP_RGB: begin
              rgb_d    = rx_data[2:0];
              rgb_we_d = 1'b1;
            end
            OP_SET, OP_CLR_PIX: begin
              bit_d   = (rx_data[7:4] == OP_SET);
              state_d = ARG_PIX;
              cnt_d   = '0;
            end
            OP_CLS: clr_d = 1'b1;
            OP_COL: begin
              col_d   = rx_data[3:0];
              state_d = ARG_COL;
              cnt_d   = '0;
            end
            OP_CTRL: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      ARG_PIX, ARG_COL: begin
        // An arriving byte takes priority over the timeout expiring on the same cycle.
        if (rx_dv) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_data == RESYNC_BYTE) begin
          end else if (state_q == ARG_PIX) begin
            if (rx_data[3]) begin
              err_d = 1'b1;
            end else begin
              col_d    = rx_data[7:4];
              row_d    = rx_data[2:0];
              pix_we_d = 1'b1;
            end
          end else begin
            col_data_d = rx_data;
            col_we_d   = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fb_pix_we   = pix_we_q;
  assign fb_col_we   = col_we_q;
  assign fb_col      = col_q;
  assign fb_row      = row_q;
  assign fb_bit      = bit_q;
  assign fb_col_data = col_data_q;
  assign fb_clr      = clr_q;
  assign rgb_we      = rgb_we_q;
  assign rgb_val     = rgb_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_led_panel_cmd_parser.sv
// tb/tb_led_panel_cmd_parser.sv - directed self-checking bench for led_panel_cmd_parser
module tb_led_panel_cmd_parser;

  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_dv;
  logic [7:0] rx_data;
  logic       fb_pix_we, fb_col_we, fb_bit, fb_clr, rgb_we, err, busy;
  logic [3:0] fb_col;
  logic [2:0] fb_row, rgb_val;
  logic [7:0] fb_col_data;
  logic [4:0] strb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_panel_cmd_parser #(.TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_data(rx_data),
    .fb_pix_we(fb_pix_we), .fb_col_we(fb_col_we), .fb_col(fb_col),
    .fb_row(fb_row), .fb_bit(fb_bit), .fb_col_data(fb_col_data),
    .fb_clr(fb_clr), .rgb_we(rgb_we), .rgb_val(rgb_val), .err(err), .busy(busy)
  );

  // {pix_we, col_we, clr, rgb_we, err}
  assign strb = {fb_pix_we, fb_col_we, fb_clr, rgb_we, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_data = b;
    tick();
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    reset   = 1'b1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    check("rst_strb", strb, 5'b00000);
    check("rst_col", fb_col, 4'd0);
    check("rst_row", fb_row, 3'd0);
    check("rst_bit", fb_bit, 1'b0);
    check("rst_cdata", fb_col_data, 8'h00);
    check("rst_rgb", rgb_val, 3'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    send(8'h05);
    check("rgb_strb", strb, 5'b00010);
    check("rgb_val", rgb_val, 3'b101);
    tick();
    check("rgb_pulse_end", strb, 5'b00000);
    check("rgb_hold", rgb_val, 3'b101);

    send(8'h10);
    check("set_busy", busy, 1'b1);
    check("set_op_strb", strb, 5'b00000);
    send(8'h72);
    check("set_strb", strb, 5'b10000);
    check("set_col", fb_col, 4'd7);
    check("set_row", fb_row, 3'd2);
    check("set_bit", fb_bit, 1'b1);
    check("set_busy_end", busy, 1'b0);

    send(8'h20);
    send(8'h72);
    check("clrpix_strb", strb, 5'b10000);
    check("clrpix_col", fb_col, 4'd7);
    check("clrpix_row", fb_row, 3'd2);
    check("clrpix_bit", fb_bit, 1'b0);

    send(8'h4A);
    check("col_busy", busy, 1'b1);
    send(8'h3C);
    check("col_strb", strb, 5'b01000);
    check("col_col", fb_col, 4'd10);
    check("col_data", fb_col_data, 8'h3C);

    send(8'h4A);
    send(8'hF5);
    check("resync_strb", strb, 5'b00000);
    check("resync_busy", busy, 1'b0);
    check("resync_data", fb_col_data, 8'h3C);

    send(8'h10);
    send(8'h18);
    check("badarg_strb", strb, 5'b00001);
    check("badarg_col", fb_col, 4'd10);
    check("badarg_busy", busy, 1'b0);

    send(8'h77);
    check("badop_strb", strb, 5'b00001);
    check("badop_busy", busy, 1'b0);

    send(8'h30);
    check("cls_strb", strb, 5'b00100);

    send(8'hF5);
    check("nop_strb", strb, 5'b00000);
    check("nop_busy", busy, 1'b0);

    send(8'h10);
    repeat (TO - 1) tick();
    check("to_pre_err", err, 1'b0);
    check("to_pre_busy", busy, 1'b1);
    tick();
    check("to_strb", strb, 5'b00001);
    check("to_busy", busy, 1'b0);
    tick();
    check("to_once", err, 1'b0);

    send(8'h10);
    repeat (TO - 1) tick();
    send(8'h35);
    check("exp_strb", strb, 5'b10000);
    check("exp_col", fb_col, 4'd3);
    check("exp_row", fb_row, 3'd5);
    check("exp_busy", busy, 1'b0);
    tick();
    check("exp_no_err", err, 1'b0);

    send(8'h10);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_strb0", strb, 5'b00000);
    tick();
    check("rstmid_strb1", strb, 5'b00000);
    check("rstmid_col", fb_col, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
